dram_arbiter: RTL and testbench

- Two-master arbiter and sequencer in front of the 16 KiB byte-lane data RAM (4 x 8-bit x 4096, 1-cycle registered read).
- Master 0: core load/store unit. Master 1: program-download/debug port.
- Grants at most one access per cycle and drives the RAM write/read ports from the winner.
- Tags each read so its data returns to the issuing master one cycle later; rejects out-of-window addresses without touching the RAM.

---
 rtl/dram_arbiter_pkg.sv | 15 +
 rtl/dram_arb_core.sv | 57 +++++
 rtl/dram_arbiter.sv | 112 +++++++++++
 tb/tb_dram_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared types and constants for the two-master data-RAM arbiter.
package dram_arbiter_pkg;

  typedef enum logic {
    ARB     = 1'b0,
    LOCK_M1 = 1'b1
  } arb_state_e;

  // Master indices, sized to match the 1-bit source tags.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int unsigned NUM_LANES = 4;

endpackage

// File: rtl/dram_arb_core.sv
// Grant logic for two masters: m0 priority, m1 anti-starvation and m1 lock ownership.
module dram_arb_core
  import dram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic m0_req_i,
  input  logic m1_req_i,
  input  logic m1_lock_i,
  output logic m0_gnt_o,
  output logic m1_gnt_o
);

  localparam int unsigned CW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  arb_state_e    state_q;
  logic [CW-1:0] starve_q;
  logic          starved;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    starved  = (starve_q == CNT_MAX);
    m0_gnt_o = 1'b0;
    m1_gnt_o = 1'b0;
    if (state_q == LOCK_M1) begin
      m1_gnt_o = m1_req_i;
    end else begin
      m1_gnt_o = m1_req_i & (~m0_req_i | starved);
      m0_gnt_o = m0_req_i & ~m1_gnt_o;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB;
      starve_q <= '0;
    end else begin
      case (state_q)
        ARB:     if (m1_gnt_o && m1_lock_i) state_q <= LOCK_M1;
        LOCK_M1: if (!m1_lock_i) state_q <= ARB;
        default: state_q <= ARB;
      endcase

      // Only contested ARB cycles that m1 loses build up starvation.
      if (m1_gnt_o || !m1_req_i) begin
        starve_q <= '0;
      end else if (state_q == ARB && !starved) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Two-master front end for the byte-lane data RAM: winner muxing, window check and read tagging.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int unsigned          DW         = 32,
  parameter int unsigned          ADDR_BIT   = 32,
  parameter logic [ADDR_BIT-1:0]  MEM_BASE   = 'h1000_0000,
  parameter int unsigned          WIN_BIT    = 14,
  parameter int unsigned          STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 m0_req_i,
  input  logic                 m0_we_i,
  input  logic [NUM_LANES-1:0] m0_be_i,
  input  logic [ADDR_BIT-1:0]  m0_addr_i,
  input  logic [DW-1:0]        m0_wdata_i,
  output logic                 m0_gnt_o,
  output logic                 m0_rvalid_o,
  output logic [DW-1:0]        m0_rdata_o,
  output logic                 m0_err_o,

  input  logic                 m1_req_i,
  input  logic                 m1_we_i,
  input  logic [NUM_LANES-1:0] m1_be_i,
  input  logic [ADDR_BIT-1:0]  m1_addr_i,
  input  logic [DW-1:0]        m1_wdata_i,
  input  logic                 m1_lock_i,
  output logic                 m1_gnt_o,
  output logic                 m1_rvalid_o,
  output logic [DW-1:0]        m1_rdata_o,
  output logic                 m1_err_o,

  output logic [NUM_LANES-1:0] mem_wen_o,
  output logic [ADDR_BIT-1:0]  mem_waddr_o,
  output logic [DW-1:0]        mem_wdata_o,
  output logic                 mem_ren_o,
  output logic [ADDR_BIT-1:0]  mem_raddr_o,
  input  logic [DW-1:0]        mem_rdata_i
);

  logic                 gnt_any, sel_m1, win_we, win_in;
  logic [NUM_LANES-1:0] win_be;
  logic [ADDR_BIT-1:0]  win_addr;
  logic [DW-1:0]        win_wdata;

  logic rd_pend_q, rd_pend_d, rd_src_q, rd_src_d;
  logic err_pend_q, err_pend_d, err_src_q, err_src_d, err_rd_q, err_rd_d;

  dram_arb_core #(
    .STARVE_MAX (STARVE_MAX)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .m0_req_i  (m0_req_i),
    .m1_req_i  (m1_req_i),
    .m1_lock_i (m1_lock_i),
    .m0_gnt_o  (m0_gnt_o),
    .m1_gnt_o  (m1_gnt_o)
  );

  // With no grant the mux falls back to m0; the enables stay low so the RAM ignores it.
  always_comb begin
    gnt_any   = m0_gnt_o | m1_gnt_o;
    sel_m1    = m1_gnt_o;
    win_we    = sel_m1 ? m1_we_i    : m0_we_i;
    win_be    = sel_m1 ? m1_be_i    : m0_be_i;
    win_addr  = sel_m1 ? m1_addr_i  : m0_addr_i;
    win_wdata = sel_m1 ? m1_wdata_i : m0_wdata_i;
    win_in    = (win_addr[ADDR_BIT-1:WIN_BIT] == MEM_BASE[ADDR_BIT-1:WIN_BIT]);

    mem_wen_o   = (gnt_any && win_we && win_in) ? win_be : '0;
    mem_ren_o   = gnt_any && !win_we && win_in;
    mem_waddr_o = win_addr;
    mem_raddr_o = win_addr;
    mem_wdata_o = win_wdata;

    rd_pend_d  = mem_ren_o;
    rd_src_d   = sel_m1;
    err_pend_d = gnt_any && !win_in;
    err_src_d  = sel_m1;
    err_rd_d   = !win_we;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_src_q   <= M0;
      err_pend_q <= 1'b0;
      err_src_q  <= M0;
      err_rd_q   <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_src_q   <= rd_src_d;
      err_pend_q <= err_pend_d;
      err_src_q  <= err_src_d;
      err_rd_q   <= err_rd_d;
    end
  end

  // Response side decodes the registered tags; RAM data is steered only to the issuing master.
  always_comb begin
    m0_rvalid_o = (rd_pend_q && rd_src_q == M0) || (err_pend_q && err_rd_q && err_src_q == M0);
    m1_rvalid_o = (rd_pend_q && rd_src_q == M1) || (err_pend_q && err_rd_q && err_src_q == M1);
    m0_err_o    = err_pend_q && err_src_q == M0;
    m1_err_o    = err_pend_q && err_src_q == M1;
    m0_rdata_o  = (rd_pend_q && rd_src_q == M0) ? mem_rdata_i : '0;
    m1_rdata_o  = (rd_pend_q && rd_src_q == M1) ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed table, multi-cycle corner sequences, random traffic.
module tb_dram_arbiter;

  localparam int          STARVE_MAX = 4;
  localparam logic [31:0] BASE       = 32'h1000_0000;

  logic        clk, rst;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [3:0]  m0_be;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err, m1_lock;
  logic [3:0]  m1_be;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  mem_wen;
  logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;
  logic        mem_ren;

  int checks   = 0;
  int failures = 0;

  dram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
    .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_lock_i(m1_lock), .m1_gnt_o(m1_gnt),
    .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .mem_wen_o(mem_wen), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata),
    .mem_ren_o(mem_ren), .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical RAM: 4096 words, byte-lane writes, one-cycle registered read.
  logic [31:0] ram [0:4095];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_wen[b]) ram[mem_waddr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_ren) mem_rdata <= ram[mem_raddr[13:2]];
  end

  // Reference model: lock ownership flag, m1 denial streak, shadow memory, expected responses.
  bit          mdl_locked;
  int          mdl_streak;
  logic [31:0] shadow [0:4095];
  bit          exp_rv  [2];
  bit          exp_err [2];
  logic [31:0] exp_dat [2];
  logic        obs_g0, obs_g1;

  typedef struct {
    bit r0; bit w0; logic [3:0] be0; logic [31:0] a0; logic [31:0] d0;
    bit r1; bit w1; logic [3:0] be1; logic [31:0] a1; logic [31:0] d1;
    bit lk;
  } stim_t;

  typedef struct {
    bit r0; bit r1; bit lk;
    bit g0; bit g1;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{r0: 0, w0: 0, be0: 4'h0, a0: BASE, d0: 32'h0,
          r1: 0, w1: 0, be1: 4'h0, a1: BASE, d1: 32'h0, lk: 0};
    return s;
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'h2000_0000 | 32'($urandom_range(0, 255));
    return BASE | ($urandom & 32'h0000_3FFF);
  endfunction

  task automatic drive(input stim_t s);
    m0_req = s.r0; m0_we = s.w0; m0_be = s.be0; m0_addr = s.a0; m0_wdata = s.d0;
    m1_req = s.r1; m1_we = s.w1; m1_be = s.be1; m1_addr = s.a1; m1_wdata = s.d1;
    m1_lock = s.lk;
  endtask

  task automatic model_reset();
    mdl_locked = 0;
    mdl_streak = 0;
    for (int m = 0; m < 2; m++) begin
      exp_rv[m] = 0; exp_err[m] = 0; exp_dat[m] = 32'h0;
    end
  endtask

  // One clock cycle: called at a falling edge, returns at the next falling edge.
  task automatic cycle(input stim_t s);
    bit          g0, g1, w, inw, any;
    int          src;
    logic [31:0] a, d;
    logic [3:0]  be, exp_wen;
    drive(s);
    #1;
    if (mdl_locked) begin
      g0 = 0; g1 = s.r1;
    end else if (s.r0 && s.r1) begin
      g1 = (mdl_streak >= STARVE_MAX); g0 = !g1;
    end else begin
      g0 = s.r0; g1 = s.r1;
    end
    obs_g0 = m0_gnt; obs_g1 = m1_gnt;
    check("m0_gnt", m0_gnt, 32'(g0));
    check("m1_gnt", m1_gnt, 32'(g1));

    any = g0 || g1;
    src = g1 ? 1 : 0;
    w   = g1 ? s.w1  : s.w0;
    a   = g1 ? s.a1  : s.a0;
    d   = g1 ? s.d1  : s.d0;
    be  = g1 ? s.be1 : s.be0;
    inw = ((a >> 14) == (BASE >> 14));
    exp_wen = (any && w && inw) ? be : 4'h0;
    check("mem_ren", mem_ren, 32'(any && !w && inw));
    check("mem_wen", mem_wen, 32'(exp_wen));
    if (any && !w && inw) check("mem_raddr", mem_raddr, a);
    if (exp_wen != 4'h0) begin
      check("mem_waddr", mem_waddr, a);
      check("mem_wdata", mem_wdata, d);
    end

    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      exp_rv[m] = 0; exp_err[m] = 0; exp_dat[m] = 32'h0;
    end
    if (any) begin
      if (!inw) begin
        exp_err[src] = 1;
        exp_rv[src]  = !w;
      end else if (!w) begin
        exp_rv[src]  = 1;
        exp_dat[src] = shadow[a[13:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (be[b]) shadow[a[13:2]][8*b +: 8] = d[8*b +: 8];
      end
    end
    if (!mdl_locked && s.r1 && !g1) mdl_streak = (mdl_streak < STARVE_MAX) ? mdl_streak + 1 : STARVE_MAX;
    else mdl_streak = 0;
    if (mdl_locked) begin
      if (!s.lk) mdl_locked = 0;
    end else if (g1 && s.lk) begin
      mdl_locked = 1;
    end

    @(negedge clk);
    check("m0_rvalid", m0_rvalid, 32'(exp_rv[0]));
    check("m1_rvalid", m1_rvalid, 32'(exp_rv[1]));
    check("m0_err",    m0_err,    32'(exp_err[0]));
    check("m1_err",    m1_err,    32'(exp_err[1]));
    check("m0_rdata",  m0_rdata,  exp_dat[0]);
    check("m1_rdata",  m1_rdata,  exp_dat[1]);
  endtask

  vec_t  tbl [12];
  stim_t s;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]    = {i[15:0], ~i[15:0]};
      shadow[i] = {i[15:0], ~i[15:0]};
    end
    model_reset();
    rst = 1'b1;
    drive(idle());
    repeat (2) @(negedge clk);
    check("rst_m0_rvalid", m0_rvalid, 32'h0);
    check("rst_m1_rvalid", m1_rvalid, 32'h0);
    check("rst_m0_err",    m0_err,    32'h0);
    check("rst_m0_rdata",  m0_rdata,  32'h0);
    rst = 1'b0;

    // Partial write then read-back: low half updated, upper half keeps prior contents.
    s = idle(); s.r0 = 1; s.w0 = 1; s.be0 = 4'b0011; s.a0 = 32'h1000_0004; s.d0 = 32'hAABB_CCDD;
    cycle(s);
    s = idle(); s.r0 = 1; s.a0 = 32'h1000_0004;
    cycle(s);
    check("wr_rd_data", m0_rdata, 32'h0001_CCDD);

    // Out-of-window read: no RAM access, error response with zero data.
    s = idle(); s.r0 = 1; s.a0 = 32'h2000_0000;
    cycle(s);
    check("oow_err", m0_err, 32'h1);
    check("oow_rvalid", m0_rvalid, 32'h1);

    // Back-to-back reads return in order on consecutive cycles.
    s = idle(); s.r0 = 1; s.a0 = 32'h1000_0000;
    cycle(s);
    check("b2b_first", m0_rdata, 32'h0000_FFFF);
    s.a0 = 32'h1000_0008;
    cycle(s);
    check("b2b_second", m0_rdata, 32'h0002_FFFD);

    // Starvation release after four denials, then lock ownership and release.
    tbl[0]  = '{1, 1, 0, 1, 0};
    tbl[1]  = '{1, 1, 0, 1, 0};
    tbl[2]  = '{1, 1, 0, 1, 0};
    tbl[3]  = '{1, 1, 0, 1, 0};
    tbl[4]  = '{1, 1, 0, 0, 1};
    tbl[5]  = '{1, 1, 0, 1, 0};
    tbl[6]  = '{0, 1, 1, 0, 1};
    tbl[7]  = '{1, 0, 1, 0, 0};
    tbl[8]  = '{1, 0, 1, 0, 0};
    tbl[9]  = '{1, 0, 1, 0, 0};
    tbl[10] = '{1, 0, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 1, 0};
    for (int i = 0; i < 12; i++) begin
      s = idle();
      s.r0 = tbl[i].r0; s.a0 = BASE + 32'h10 + 32'(4 * i);
      s.r1 = tbl[i].r1; s.a1 = BASE + 32'h100 + 32'(4 * i);
      s.lk = tbl[i].lk;
      cycle(s);
      check($sformatf("tbl%0d_g0", i), obs_g0, 32'(tbl[i].g0));
      check($sformatf("tbl%0d_g1", i), obs_g1, 32'(tbl[i].g1));
    end

    // Async reset with an m1 read in flight while locked.
    s = idle(); s.r1 = 1; s.lk = 1; s.a1 = BASE + 32'h40;
    cycle(s);
    s.r0 = 1;
    drive(s);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_m1_rvalid", m1_rvalid, 32'h0);
    check("arst_m1_err",    m1_err,    32'h0);
    check("arst_state_m0_gnt", m0_gnt, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(idle());

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      s.r0  = ($urandom_range(0, 3) != 0);
      s.w0  = $urandom_range(0, 1) == 1;
      s.be0 = 4'($urandom_range(0, 15));
      s.a0  = rand_addr();
      s.d0  = $urandom;
      s.r1  = ($urandom_range(0, 2) != 0);
      s.w1  = $urandom_range(0, 1) == 1;
      s.be1 = 4'($urandom_range(0, 15));
      s.a1  = rand_addr();
      s.d1  = $urandom;
      s.lk  = ($urandom_range(0, 4) == 0) || (mdl_locked && $urandom_range(0, 2) != 0);
      cycle(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
